// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - stream front end issuing jobs to the GCD core with timeout guard
module gcd_requester #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic             gcd_start,
    input  logic [WIDTH-1:0] gcd_y,
    input  logic             gcd_done,
    input  logic             gcd_error,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_err,
    output logic             out_tmo,
    output logic [7:0]       job_cnt,
    output logic [7:0]       err_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          in_fire, out_fire, zero_op, tmo_hit;

    assign in_ready  = (state == S_IDLE);
    assign gcd_start = (state == S_ISSUE);
    assign out_valid = (state == S_HOLD);
    assign in_fire   = in_ready && in_valid;
    assign out_fire  = out_valid && out_ready;
    assign zero_op   = (in_a == '0) || (in_b == '0);
    assign tmo_hit   = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_fire) state_nxt = zero_op ? S_HOLD : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (gcd_done || tmo_hit) state_nxt = S_HOLD;
            S_HOLD:  if (out_fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result registers load only on the transition into HOLD, so DONE outside WAIT is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcd_a   <= '0;
            gcd_b   <= '0;
            out_y   <= '0;
            out_err <= 1'b0;
            out_tmo <= 1'b0;
            timer   <= '0;
            job_cnt <= 8'd0;
            err_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        if (zero_op) begin
                            out_y   <= '0;
                            out_err <= 1'b1;
                            out_tmo <= 1'b0;
                        end else begin
                            gcd_a <= in_a;
                            gcd_b <= in_b;
                        end
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (gcd_done) begin
                        out_y   <= gcd_y;
                        out_err <= gcd_error;
                        out_tmo <= 1'b0;
                    end else if (tmo_hit) begin
                        out_y   <= '0;
                        out_err <= 1'b1;
                        out_tmo <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_fire) begin
                        job_cnt <= job_cnt + 8'd1;
                        if (out_err) err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - directed self-checking bench for gcd_requester
module tb_gcd_requester;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [7:0] gcd_a, gcd_b;
    logic       gcd_start;
    logic [7:0] gcd_y;
    logic       gcd_done;
    logic       gcd_error;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_err;
    logic       out_tmo;
    logic [7:0] job_cnt, err_cnt;

    logic       core_done = 1'b0;
    logic       inj_done;
    logic       core_en;
    logic       core_err;
    int         core_delay;
    int         rel = 0;
    int         start_cnt = 0;
    int         total = 0;
    int         bad = 0;

    gcd_requester #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
        .gcd_y(gcd_y), .gcd_done(gcd_done), .gcd_error(gcd_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_err(out_err), .out_tmo(out_tmo),
        .job_cnt(job_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gcd_fn(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stand-in core: answers core_delay cycles after the START cycle when enabled.
    assign gcd_done  = core_done | inj_done;
    assign gcd_error = core_err;

    always @(posedge clk) begin
        if (gcd_start) begin
            rel       <= 1;
            core_done <= core_en && (core_delay == 1);
            gcd_y     <= gcd_fn(gcd_a, gcd_b);
            start_cnt <= start_cnt + 1;
        end else if (rel != 0) begin
            rel       <= rel + 1;
            core_done <= core_en && (rel + 1 == core_delay);
        end else begin
            core_done <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Returns with the bench at the negedge of the first OUT_VALID cycle (or the bound).
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, output int lat, output logic st1);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        st1      = gcd_start;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic st1;
        int   sc;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_a       = 8'd7;
        in_b       = 8'd3;
        out_ready  = 1'b1;
        inj_done   = 1'b0;
        core_en    = 1'b1;
        core_err   = 1'b0;
        core_delay = 5;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_start", gcd_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_regs", {gcd_a, gcd_b, out_y, out_err, out_tmo, job_cnt, err_cnt}, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        // normal job
        run_job(8'd48, 8'd36, lat, st1);
        check("norm_start", st1, 1);
        check("norm_lat", lat, 7);
        check("norm_ab", {gcd_a, gcd_b}, {8'd48, 8'd36});
        check("norm_y", out_y, 12);
        check("norm_err_tmo", {out_err, out_tmo}, 0);
        @(negedge clk);
        check("norm_cnt", {job_cnt, err_cnt}, {8'd1, 8'd0});
        check("norm_starts", start_cnt, 1);
        check("norm_idle", in_ready, 1);

        // zero operand reject
        run_job(8'd0, 8'd9, lat, st1);
        check("rej_start", st1, 0);
        check("rej_lat", lat, 1);
        check("rej_out", {out_y, out_err, out_tmo}, {8'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("rej_cnt", {job_cnt, err_cnt}, {8'd2, 8'd1});
        check("rej_starts", start_cnt, 1);

        // timeout then late DONE in IDLE
        core_en = 1'b0;
        run_job(8'd5, 8'd10, lat, st1);
        check("tmo_lat", lat, 18);
        check("tmo_out", {out_y, out_err, out_tmo}, {8'd0, 1'b1, 1'b1});
        @(negedge clk);
        check("tmo_cnt", {job_cnt, err_cnt}, {8'd3, 8'd2});
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("late_valid", out_valid, 0);
        check("late_ready", in_ready, 1);
        check("late_out", {out_y, out_err, out_tmo}, {8'd0, 1'b1, 1'b1});
        check("late_cnt", {job_cnt, err_cnt}, {8'd3, 8'd2});

        // backpressure
        core_en   = 1'b1;
        out_ready = 1'b0;
        run_job(8'd20, 8'd8, lat, st1);
        check("bp_lat", lat, 7);
        sc = start_cnt;
        in_valid = 1'b1;
        in_a     = 8'd3;
        in_b     = 8'd3;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {out_valid, in_ready, out_y, out_err, out_tmo}, {1'b1, 1'b0, 8'd4, 1'b0, 1'b0});
            check("bp_cnt", job_cnt, 3);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_cnt_after", {job_cnt, err_cnt}, {8'd4, 8'd2});
        check("bp_starts", start_cnt, sc);

        // core error then counter wrap, from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        core_err = 1'b1;
        run_job(8'd6, 8'd4, lat, st1);
        check("cerr_out", {out_y, out_err, out_tmo}, {8'd2, 1'b1, 1'b0});
        @(negedge clk);
        check("cerr_cnt", {job_cnt, err_cnt}, {8'd1, 8'd1});
        core_err   = 1'b0;
        core_delay = 1;
        for (int j = 0; j < 256; j++) begin
            run_job(8'd12, 8'd18, lat, st1);
            check("b2b_lat", lat, 3);
            check("b2b_y", {out_y, out_err}, {8'd6, 1'b0});
        end
        @(negedge clk);
        check("wrap_cnt", {job_cnt, err_cnt}, {8'd1, 8'd1});

        // reset while waiting on the core
        core_en = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'd17;
        in_b     = 8'd51;
        @(negedge clk);
        in_valid = 1'b0;
        check("rw_start", gcd_start, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rw_zero", {gcd_start, out_valid, gcd_a, gcd_b, out_y, out_err, out_tmo, job_cnt, err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rw_ready", in_ready, 1);
        core_en    = 1'b1;
        core_delay = 3;
        @(negedge clk);
        run_job(8'd17, 8'd51, lat, st1);
        check("rw_lat", lat, 5);
        check("rw_y", {out_y, out_err}, {8'd17, 1'b0});
        @(negedge clk);
        check("rw_cnt", {job_cnt, err_cnt}, {8'd1, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gcd_requester.md
# gcd_requester

Initiator-side front end for the 8-bit GCD unit. It accepts operand pairs from an upstream valid/ready stream, drives the GCD unit's START/A/B request, and waits for DONE/Y/ERROR. It returns each result on a downstream valid/ready stream and keeps job and error counters. It sits between a command source (CPU register block or test sequencer) and the GCD core, and adds a timeout guard against a hung core.

## Interface
- WIDTH, 8: operand/result width; must match the GCD core.
- TIMEOUT, 512: maximum cycles spent in WAIT before the job is abandoned. Must be ≥ 2. Timer width is ceil(log2(TIMEOUT+1)).
- Clocking and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream operand pair valid.
- IN_READY  out  1  high only in IDLE (combinational from state).
- IN_A, IN_B  in  WIDTH  operands, sampled on the IN handshake.
- GCD_A, GCD_B  out  WIDTH  registered operands presented to the core.
- GCD_START  out  1  one-cycle request pulse to the core.
- GCD_Y  in  WIDTH  core result, valid when GCD_DONE=1.
- GCD_DONE  in  1  core completion pulse.
- GCD_ERROR  in  1  core error flag, valid with GCD_DONE.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts the result.
- OUT_Y  out  WIDTH  result.
- OUT_ERR  out  1  error: core error, local zero-operand reject, or timeout.
- OUT_TMO  out  1  result produced by timeout.
- JOB_CNT  out  8  completed jobs (OUT handshakes); wraps 255→0.
- ERR_CNT  out  8  completed jobs with OUT_ERR=1; wraps 255→0.

## Operation
- States are IDLE, ISSUE, WAIT, HOLD. Reset enters IDLE.
- IDLE: IN_READY=1. On IN_VALID:
  - If IN_A==0 or IN_B==0, it performs a local reject: OUT_Y←0, OUT_ERR←1, OUT_TMO←0, go to HOLD. The core is not started.
  - Otherwise GCD_A←IN_A, GCD_B←IN_B, go to ISSUE.
- ISSUE: GCD_START=1 for exactly this one cycle. Timer cleared. Go to WAIT.
- WAIT: timer increments every cycle.
  - If GCD_DONE=1: OUT_Y←GCD_Y, OUT_ERR←GCD_ERROR, OUT_TMO←0, go to HOLD.
  - Otherwise, if timer==TIMEOUT-1: OUT_Y←0, OUT_ERR←1, OUT_TMO←1, go to HOLD.
  - If DONE and timeout occur in the same cycle, DONE wins.
- HOLD: OUT_VALID=1. OUT_Y, OUT_ERR and OUT_TMO stay stable until OUT_READY=1. On the handshake:
  - JOB_CNT increments.
  - ERR_CNT increments if OUT_ERR=1.
  - Go to IDLE.
- GCD_DONE seen outside WAIT is ignored. This covers a late DONE after a timeout. It must not alter outputs or counters.
- GCD_A and GCD_B hold their values from ISSUE until the next accepted job.
- Reset mid-operation, at any state, is immediate: state→IDLE, GCD_START=0, OUT_VALID=0, counters cleared. The pending job is discarded.

## Timing
- Reset values are all 0: GCD_A, GCD_B, GCD_START, OUT_VALID, OUT_Y, OUT_ERR, OUT_TMO, JOB_CNT, ERR_CNT, timer. IN_READY=1 while in reset and IN_VALID is ignored.
- The IN handshake occurs at edge k. GCD_START is high in cycle k+1, i.e. between edge k and edge k+1.
- The core's DONE is sampled at edge m in WAIT. OUT_VALID is high from cycle m+1.
- Local reject: OUT_VALID is high in cycle k+1.
- Timeout: if no DONE occurs, OUT_VALID rises exactly TIMEOUT+1 cycles after GCD_START.
- Back-to-back jobs: after the OUT handshake at edge n, IN_READY=1 in cycle n+1. The minimum job period is 4 cycles: IDLE, ISSUE, WAIT with immediate DONE, HOLD with OUT_READY already high.
- The block never has more than one job outstanding.

## Test plan
- Normal job: IN_A=48, IN_B=36 with a core model answering DONE 5 cycles after START, OUT_READY=1 → GCD_START pulses once with GCD_A=48 and GCD_B=36; OUT_Y=12, OUT_ERR=0; JOB_CNT=1, ERR_CNT=0.
- Zero operand: IN_A=0, IN_B=9 → no GCD_START; OUT_VALID is high the next cycle with OUT_Y=0 and OUT_ERR=1; ERR_CNT=1.
- Timeout: TIMEOUT=16 and the core never asserts DONE → OUT_VALID rises 17 cycles after START with OUT_ERR=1 and OUT_TMO=1. A late DONE injected in the next IDLE period is ignored.
- Backpressure: hold OUT_READY=0 for 10 cycles after the result → OUT_VALID and OUT_Y are stable, IN_READY=0 throughout, and IN_VALID is ignored. The counters increment only once OUT_READY goes high.
- Core error and counter wrap: the core returns DONE with ERROR=1; then 256 good jobs run → ERR_CNT=1 and JOB_CNT wraps to 1.
- Reset in WAIT: deassert RST_N 3 cycles after START → all outputs are 0 immediately and IN_READY=1 after release. A subsequent job of 17 and 51 returns 17.
